// File: rtl/md_stream_pkg.sv
// Shared definitions for the cell position streamer.
//   MEM_LATENCY : cycles from a cell memory read enable to valid read data.
//   ST_*        : FSM state encoding used by cell_pos_streamer.
package md_stream_pkg;

  localparam int MEM_LATENCY = 2;

  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] ST_IDLE     = 3'd0;
  localparam logic [STATE_W-1:0] ST_RD_CNT   = 3'd1;
  localparam logic [STATE_W-1:0] ST_WAIT_CNT = 3'd2;
  localparam logic [STATE_W-1:0] ST_STREAM   = 3'd3;
  localparam logic [STATE_W-1:0] ST_DRAIN    = 3'd4;

endpackage

// File: rtl/pos_stream_fifo.sv
// Show-ahead synchronous FIFO used as the streamer's output buffer.
//   clk, rst_n   : clock, async active-low reset (clears pointers/count)
//   push_i       : write push_data_i (ignored when full and not popping)
//   pop_i        : consume the head entry (ignored when empty)
//   pop_data_o   : head entry, valid whenever count_o != 0
//   count_o      : current occupancy, 0..DEPTH
module pos_stream_fifo #(
  parameter int WIDTH = 104,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic             do_push, do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  assign do_push = push_i && ((count_q != CW'(DEPTH)) || do_pop);

  // NOTE: the storage array has no reset; the pointers alone decide which
  // entries are valid, so clearing the data would only cost reset fan-out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;

endmodule

// File: rtl/cell_pos_streamer.sv
// Reads one cell from the cell memory and streams its particle positions.
// Address 0 holds the particle count; addresses 1..count hold the
// {posz, posy, posx} words, which are emitted in order on a valid/ready
// stream tagged with their source address.
//   clk, rst_n      : clock, async active-low reset
//   start           : one-cycle pulse, begins a readout (ignored while busy)
//   busy, done      : readout in progress / one-cycle completion pulse
//   mem_address, mem_rden, mem_wren, mem_q : cell memory port (read only)
//   particle_count  : saturated count latched for the current cell
//   out_data, out_index, out_valid, out_ready, out_last : output stream
module cell_pos_streamer
  import md_stream_pkg::*;
#(
  parameter int DATA_WIDTH   = 96,
  parameter int ADDR_WIDTH   = 8,
  parameter int PARTICLE_NUM = 220,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_rden,
  output logic                  mem_wren,
  input  logic [DATA_WIDTH-1:0] mem_q,
  output logic [ADDR_WIDTH-1:0] particle_count,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ADDR_WIDTH-1:0] out_index,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last
);

  localparam int FIFO_W = DATA_WIDTH + ADDR_WIDTH;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;
  localparam int PW     = CW + 1;
  localparam logic [ADDR_WIDTH-1:0] CNT_MAX   = ADDR_WIDTH'(PARTICLE_NUM - 1);
  localparam logic [1:0]            WAIT_LAST = 2'(MEM_LATENCY - 1);

  logic [STATE_W-1:0]    state_q, state_d;
  logic [1:0]            wait_q, wait_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] count_q, count_d;

  // In-flight reads: one valid/index stage per cycle of memory latency.
  logic [MEM_LATENCY-1:0] infl_vld_q;
  logic [ADDR_WIDTH-1:0]  infl_idx_q [MEM_LATENCY];

  logic [CW-1:0]         fifo_count;
  logic [FIFO_W-1:0]     fifo_head;
  logic [PW-1:0]         pending;
  logic                  issue, drained, fifo_pop;
  logic [ADDR_WIDTH-1:0] cnt_raw, cnt_sat;

  // Reads are only issued while every outstanding word is guaranteed a FIFO
  // slot, so backpressure can never drop returning data.
  always_comb begin
    pending = PW'(fifo_count);
    for (int i = 0; i < MEM_LATENCY; i++) pending = pending + PW'(infl_vld_q[i]);
  end

  assign issue   = (state_q == ST_STREAM) && (pending < PW'(FIFO_DEPTH));
  assign drained = (infl_vld_q == '0) && (fifo_count == '0);
  assign cnt_raw = mem_q[ADDR_WIDTH-1:0];
  assign cnt_sat = (cnt_raw > CNT_MAX) ? CNT_MAX : cnt_raw;

  // NOTE: every always_comb output gets a default first so no path through
  // the case statement leaves a variable unassigned and infers a latch.
  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    addr_d  = addr_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RD_CNT;
      ST_RD_CNT: begin
        wait_d  = '0;
        state_d = ST_WAIT_CNT;
      end
      ST_WAIT_CNT: begin
        if (wait_q == WAIT_LAST) begin
          count_d = cnt_sat;
          addr_d  = ADDR_WIDTH'(1);
          state_d = (cnt_sat == '0) ? ST_DRAIN : ST_STREAM;
        end else begin
          wait_d = wait_q + 2'd1;
        end
      end
      ST_STREAM: begin
        if (issue) begin
          addr_d = addr_q + ADDR_WIDTH'(1);
          if (addr_q == count_q) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: if (drained) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of the others regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      wait_q     <= '0;
      addr_q     <= '0;
      count_q    <= '0;
      infl_vld_q <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) infl_idx_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      wait_q        <= wait_d;
      addr_q        <= addr_d;
      count_q       <= count_d;
      infl_vld_q    <= {infl_vld_q[MEM_LATENCY-2:0], issue};
      infl_idx_q[0] <= addr_q;
      for (int i = 1; i < MEM_LATENCY; i++) infl_idx_q[i] <= infl_idx_q[i-1];
    end
  end

  pos_stream_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .push_i      (infl_vld_q[MEM_LATENCY-1]),
    .push_data_i ({mem_q, infl_idx_q[MEM_LATENCY-1]}),
    .pop_i       (fifo_pop),
    .pop_data_o  (fifo_head),
    .count_o     (fifo_count)
  );

  assign out_valid = (fifo_count != '0);
  assign fifo_pop  = out_valid && out_ready;
  // Head is gated so stale buffer contents never show when nothing is valid.
  assign out_data  = out_valid ? fifo_head[FIFO_W-1:ADDR_WIDTH] : '0;
  assign out_index = out_valid ? fifo_head[ADDR_WIDTH-1:0] : '0;
  assign out_last  = out_valid && (fifo_head[ADDR_WIDTH-1:0] == count_q);

  assign mem_rden       = (state_q == ST_RD_CNT) || issue;
  assign mem_address    = issue ? addr_q : '0;
  assign mem_wren       = 1'b0;
  assign particle_count = count_q;
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DRAIN) && drained;

endmodule

// File: tb/tb_cell_pos_streamer.sv
// Directed bench for cell_pos_streamer with a 2-cycle-latency cell memory.
module tb_cell_pos_streamer;

  localparam int DW = 96;
  localparam int AW = 8;
  localparam int PN = 220;
  localparam int FD = 4;
  localparam logic [DW-1:0] POISON = {3{32'hDEAD_BEEF}};

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          out_ready = 1'b1;
  logic          busy, done, mem_rden, mem_wren, out_valid, out_last;
  logic [AW-1:0] mem_address, particle_count, out_index;
  logic [DW-1:0] out_data;
  logic [DW-1:0] mem_q = POISON;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  cell_pos_streamer #(
    .DATA_WIDTH   (DW),
    .ADDR_WIDTH   (AW),
    .PARTICLE_NUM (PN),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_rden       (mem_rden),
    .mem_wren       (mem_wren),
    .mem_q          (mem_q),
    .particle_count (particle_count),
    .out_data       (out_data),
    .out_index      (out_index),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_last       (out_last)
  );

  // Cell memory model: address registered, data registered one cycle later.
  logic [DW-1:0] mem [PN];
  logic          p1_vld = 1'b0;
  logic [AW-1:0] p1_addr = '0;

  always @(posedge clk) begin
    p1_vld  <= mem_rden;
    p1_addr <= mem_address;
    mem_q   <= (p1_vld && int'(p1_addr) < PN) ? mem[p1_addr] : POISON;
  end

  function automatic logic [DW-1:0] exp_word(input int i);
    return {32'h3000_0000 + 32'(i), 32'h2000_0000 + 32'(i), 32'h1000_0000 + 32'(i)};
  endfunction

  // Monitor, sampled on the falling edge.
  int            cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int            clr_gen = 0, seen_gen = 0;
  logic [AW-1:0] rd_addrs [$];
  logic [AW-1:0] beat_idx [$];
  logic [DW-1:0] beat_data [$];
  logic          beat_last [$];
  int            done_cnt, done_cyc, start_cyc, first_cyc, last_cyc;
  int            issued, accepted, max_out, stall_err;
  bit            start_seen, prev_stall;
  logic [DW-1:0] prev_data;
  logic [AW-1:0] prev_idx;
  logic          prev_last;

  always @(negedge clk) begin
    if (clr_gen != seen_gen) begin
      seen_gen = clr_gen;
      rd_addrs.delete(); beat_idx.delete(); beat_data.delete(); beat_last.delete();
      done_cnt = 0; done_cyc = 0; start_cyc = 0; first_cyc = 0; last_cyc = 0;
      issued = 0; accepted = 0; max_out = 0; stall_err = 0; start_seen = 0;
    end
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (start && !start_seen) begin start_seen = 1; start_cyc = cyc; end
      if (mem_rden) begin
        rd_addrs.push_back(mem_address);
        if (mem_address != '0) issued++;
      end
      if (prev_stall && !(out_valid && out_data === prev_data &&
                          out_index === prev_idx && out_last === prev_last))
        stall_err++;
      if (out_valid && out_ready) begin
        beat_idx.push_back(out_index);
        beat_data.push_back(out_data);
        beat_last.push_back(out_last);
        if (beat_idx.size() == 1) first_cyc = cyc;
        last_cyc = cyc;
        accepted++;
      end
      if (issued - accepted > max_out) max_out = issued - accepted;
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_idx   = out_index;
      prev_last  = out_last;
      if (done) begin done_cnt++; done_cyc = cyc; end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    clr_gen++;
    @(negedge clk);
  endtask

  // Loads the count word, pulses start and waits (bounded) for done.
  task automatic run_cell(input logic [DW-1:0] cnt_word, input bit toggle,
                          input int restart_at, input int budget);
    int k;
    bit restarted;
    mem[0] = cnt_word;
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    restarted = 0;
    while (done_cnt == 0 && k < budget) begin
      out_ready = toggle ? (k % 4 == 0 || k % 4 == 3) : 1'b1;
      start = 1'b0;
      if (restart_at >= 0 && !restarted && beat_idx.size() >= restart_at) begin
        start = 1'b1;
        restarted = 1;
      end
      @(posedge clk); #1;
      k++;
    end
    start = 1'b0;
    out_ready = 1'b1;
    check("done_timeout", done_cnt == 0, 1'b0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic check_beats(input int n);
    check("beat_count", beat_idx.size(), n);
    for (int i = 0; i < n && i < beat_idx.size(); i++) begin
      check($sformatf("beat%0d_idx", i + 1), beat_idx[i], i + 1);
      check($sformatf("beat%0d_data", i + 1), beat_data[i], exp_word(i + 1));
      check($sformatf("beat%0d_last", i + 1), beat_last[i], i == n - 1);
    end
  endtask

  initial begin
    int k;
    for (int i = 1; i < PN; i++) mem[i] = exp_word(i);
    mem[0] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", out_valid, 1'b0);
    check("rst_last", out_last, 1'b0);
    check("rst_rden", mem_rden, 1'b0);
    check("rst_addr", mem_address, 8'd0);
    check("rst_count", particle_count, 8'd0);
    check("rst_wren", mem_wren, 1'b0);
    #2 rst_n = 1'b1;

    // Count = 5 (upper bits of the count word are ignored), ready high
    run_cell({64'hDEAD_BEEF_0BAD_F00D, 32'h0000_0105}, 1'b0, -1, 100);
    check("c5_count", particle_count, 8'd5);
    check("c5_nreads", rd_addrs.size(), 6);
    for (int i = 0; i < 6 && i < rd_addrs.size(); i++)
      check($sformatf("c5_rdaddr%0d", i), rd_addrs[i], i);
    check_beats(5);
    check("c5_done_cnt", done_cnt, 1);
    check("c5_first_lat", (first_cyc - start_cyc) <= 7, 1'b1);
    check("c5_throughput", last_cyc - first_cyc, 4);
    check("c5_busy_after", busy, 1'b0);
    check("c5_wren", mem_wren, 1'b0);

    // Count = 0
    run_cell(96'd0, 1'b0, -1, 40);
    check("c0_beats", beat_idx.size(), 0);
    check("c0_done_cnt", done_cnt, 1);
    check("c0_done_lat", done_cyc - start_cyc, 4);
    check("c0_nreads", rd_addrs.size(), 1);

    // Count = 10 with out_ready toggling 1-0-0-1
    run_cell(96'd10, 1'b1, -1, 200);
    check("c10_count", particle_count, 8'd10);
    check_beats(10);
    check("c10_stall_stable", stall_err, 0);
    check("c10_max_out_ok", max_out <= FD, 1'b1);
    check("c10_done_cnt", done_cnt, 1);

    // Count word 255 saturates to PARTICLE_NUM-1
    run_cell(96'd255, 1'b0, -1, 400);
    check("c255_count", particle_count, 8'd219);
    check_beats(219);
    check("c255_done_cnt", done_cnt, 1);

    // Second start mid-stream is ignored
    run_cell(96'd8, 1'b0, 2, 100);
    check_beats(8);
    check("restart_done_cnt", done_cnt, 1);
    check("restart_nreads", rd_addrs.size(), 9);

    // Reset after beat 3 of 8
    mem[0] = 96'd8;
    clear_mon();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    k = 0;
    while (beat_idx.size() < 3 && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    check("mid_rst_reach_beat3", beat_idx.size() >= 3, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_valid", out_valid, 1'b0);
    check("mid_rst_last", out_last, 1'b0);
    check("mid_rst_rden", mem_rden, 1'b0);
    check("mid_rst_addr", mem_address, 8'd0);
    check("mid_rst_count", particle_count, 8'd0);
    check("mid_rst_data", out_data, 96'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    clear_mon();
    repeat (20) @(posedge clk);
    #1;
    check("post_rst_beats", beat_idx.size(), 0);
    check("post_rst_done", done_cnt, 0);
    check("post_rst_reads", rd_addrs.size(), 0);
    check("post_rst_busy", busy, 1'b0);

    run_cell(96'd8, 1'b0, -1, 100);
    check("replay_first_addr", (rd_addrs.size() > 0) ? rd_addrs[0] : 8'hFF, 8'd0);
    check_beats(8);
    check("replay_done_cnt", done_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
